fire2_squeeze_ofm_writer: RTL

- Sink end of the squeeze-layer output interface.
- Captures the CH parallel rectified ofm words whenever the layer pulses its sample strobe.
- Serializes the words one channel per cycle into the activation RAM write port, using channel-major addressing.
- After the last pixel of the layer is written, returns the single-cycle ram_feedback pulse that the layer uses to drop its finish flag.

---
 rtl/fire_pkg.sv | 9 +
 rtl/fire2_squeeze_ofm_writer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fire_pkg.sv
// fire_pkg: shared types and address helper for the fire2 squeeze ofm writer
package fire_pkg;
  localparam int WIDTH = 16;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_e;
  function automatic int unsigned ofm_addr(input int unsigned base, input int unsigned ch,
                                           input int unsigned pix, input int unsigned pixels);
    return base + ch * pixels + pix;
  endfunction
endpackage

// File: rtl/fire2_squeeze_ofm_writer.sv
// fire2_squeeze_ofm_writer: serializes parallel ofm samples into channel-major activation RAM writes
module fire2_squeeze_ofm_writer
  import fire_pkg::*;
#(
  parameter int WOUT      = 64,
  parameter int CH        = 16,
  parameter int WIDTH     = fire_pkg::WIDTH,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              sample_i,
  input  logic [WIDTH-1:0]  ofm_i [0:CH-1],
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [WIDTH-1:0]  ram_data_o,
  output logic              ram_feedback_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o
);
  localparam int unsigned PIXELS = WOUT * WOUT;
  localparam int CH_W  = CH > 1 ? $clog2(CH) : 1;
  localparam int PIX_W = PIXELS > 1 ? $clog2(PIXELS) : 1;
  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic                hold_v_q, hold_v_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                last_q, last_d;
  logic                fb_q, fb_d;
  logic                ovf_q, ovf_d;
  logic                load, capture, drop;
  logic [WIDTH-1:0]    hold_q  [0:CH-1];
  logic [WIDTH-1:0]    shift_q [0:CH-1];
  // Sequencing: hand hold to shift, walk channels then pixels, stop in DONE after the final pixel
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    pix_d   = pix_q;
    load    = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = 1'b0;
    if (state_q == IDLE && hold_v_q) begin
      load    = 1'b1;
      ch_d    = '0;
      state_d = WRITE;
    end else if (state_q == WRITE) begin
      we_d   = 1'b1;
      addr_d = ADDR_W'(ofm_addr(BASE_ADDR, 32'(ch_q), 32'(pix_q), PIXELS));
      data_d = shift_q[ch_q];
      if (ch_q == CH_W'(CH - 1)) begin
        ch_d  = '0;
        pix_d = pix_q + 1'b1;
        if (pix_q == PIX_W'(PIXELS - 1)) begin
          pix_d   = '0;
          state_d = DONE;
          last_d  = 1'b1;
        end else if (hold_v_q) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end else begin
        ch_d = ch_q + 1'b1;
      end
    end
    capture  = sample_i && !clear_i && state_q != DONE && (!hold_v_q || load);
    drop     = sample_i && !clear_i && state_q != DONE && hold_v_q && !load;
    hold_v_d = capture ? 1'b1 : (load ? 1'b0 : hold_v_q);
    ovf_d    = ovf_q || drop;
    fb_d     = last_q;
  end
  // Control state and registered outputs; clear_i restarts the pass like rst but synchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      pix_q    <= '0;
      hold_v_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      fb_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (clear_i) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      pix_q    <= '0;
      hold_v_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      fb_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      pix_q    <= pix_d;
      hold_v_q <= hold_v_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      last_q   <= last_d;
      fb_q     <= fb_d;
      ovf_q    <= ovf_d;
    end
  end
  // Word storage needs no reset: the valid bit and state gate every use
  always_ff @(posedge clk) begin
    if (capture) hold_q <= ofm_i;
    if (load) shift_q <= hold_q;
  end
  assign ram_we_o       = we_q;
  assign ram_addr_o     = addr_q;
  assign ram_data_o     = data_q;
  assign ram_feedback_o = fb_q;
  assign busy_o         = hold_v_q || state_q == WRITE;
  assign done_o         = state_q == DONE;
  assign overflow_o     = ovf_q;
endmodule
